// File: rtl/intersection_phase_scheduler.sv
// Two-approach (NS/EW) intersection phase scheduler with min/max green, yellow and all-red clearance.
// Define PED_WALK_EN to enable the pedestrian walk phase; undefined, ped_req is ignored and walk stays 0.
module intersection_phase_scheduler #(
   parameter int GREEN_MIN = 8,
   parameter int GREEN_MAX = 32,
   parameter int YELLOW_T  = 4,
   parameter int ALLRED_T  = 2,
   parameter int WALK_T    = 10,
   parameter int CNT_W     = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       ns_req,
   input  logic       ew_req,
   input  logic       ped_req,
   output logic       ns_red,
   output logic       ns_yellow,
   output logic       ns_green,
   output logic       ew_red,
   output logic       ew_yellow,
   output logic       ew_green,
   output logic       walk,
   output logic [2:0] phase
);
   typedef enum logic [2:0] {
      ALL_RED   = 3'd0,
      NS_GREEN  = 3'd1,
      NS_YELLOW = 3'd2,
      NS_CLEAR  = 3'd3,
      EW_GREEN  = 3'd4,
      EW_YELLOW = 3'd5,
      EW_CLEAR  = 3'd6,
      PED_WALK  = 3'd7
   } state_t;

   localparam logic [CNT_W-1:0] GMIN_END   = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] GMAX_END   = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] ALLRED_END = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] WALK_END   = CNT_W'(WALK_T - 1);
`ifdef PED_WALK_EN
   localparam bit PED_ON = 1'b1;
`else
   localparam bit PED_ON = 1'b0;
   logic ped_unused;
   assign ped_unused = ped_req;
`endif

   // Lamp vector order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}
   localparam logic [6:0] LAMPS_RESET = 7'b100_100_0;

   state_t           state_q, state_d, grant;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             ns_pend_q, ns_pend_d;
   logic             ew_pend_q, ew_pend_d;
   logic             ped_pend_q, ped_pend_d;
   logic             last_ns_q, last_ns_d;
   logic [6:0]       lamps_q, lamps_d;
   logic             opp_pend, last_pend;

   function automatic logic [6:0] lamp_decode(input state_t s);
      logic [6:0] l;
      case (s)
         NS_GREEN:  l = 7'b001_100_0;
         NS_YELLOW: l = 7'b010_100_0;
         EW_GREEN:  l = 7'b100_001_0;
         EW_YELLOW: l = 7'b100_010_0;
         PED_WALK:  l = {6'b100_100, PED_ON};
         default:   l = LAMPS_RESET;
      endcase
      return l;
   endfunction

   always_comb begin
      opp_pend  = last_ns_q ? ew_pend_q : ns_pend_q;
      last_pend = last_ns_q ? ns_pend_q : ew_pend_q;
      if (ped_pend_q)
         grant = PED_WALK;
      else if (!opp_pend && last_pend)  // re-grant the last approach only when the other side is idle
         grant = last_ns_q ? NS_GREEN : EW_GREEN;
      else
         grant = last_ns_q ? EW_GREEN : NS_GREEN;
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      if (enable) begin
         timer_d = timer_q + 1'b1;
         case (state_q)
            ALL_RED:   if (timer_q == ALLRED_END) state_d = grant;
            NS_GREEN:  if ((timer_q >= GMIN_END && (ew_pend_q || ped_pend_q)) || timer_q == GMAX_END)
                          state_d = NS_YELLOW;
            NS_YELLOW: if (timer_q == YELLOW_END) state_d = NS_CLEAR;
            NS_CLEAR:  if (timer_q == ALLRED_END) state_d = grant;
            EW_GREEN:  if ((timer_q >= GMIN_END && (ns_pend_q || ped_pend_q)) || timer_q == GMAX_END)
                          state_d = EW_YELLOW;
            EW_YELLOW: if (timer_q == YELLOW_END) state_d = EW_CLEAR;
            EW_CLEAR:  if (timer_q == ALLRED_END) state_d = grant;
            PED_WALK:  if (timer_q == WALK_END) state_d = ALL_RED;
            default:   state_d = ALL_RED;
         endcase
         if (state_d != state_q)
            timer_d = '0;
      end

      // Requests latch regardless of enable; entering the served phase clears its bit and wins.
      ns_pend_d = ns_pend_q | (ns_req && state_q != NS_GREEN);
      ew_pend_d = ew_pend_q | (ew_req && state_q != EW_GREEN);
      last_ns_d = last_ns_q;
      if (state_d == NS_GREEN && state_q != NS_GREEN) begin
         ns_pend_d = 1'b0;
         last_ns_d = 1'b1;
      end
      if (state_d == EW_GREEN && state_q != EW_GREEN) begin
         ew_pend_d = 1'b0;
         last_ns_d = 1'b0;
      end
`ifdef PED_WALK_EN
      ped_pend_d = ped_pend_q | ped_req;
      if (state_d == PED_WALK && state_q != PED_WALK)
         ped_pend_d = 1'b0;
`else
      ped_pend_d = 1'b0;
`endif
      lamps_d = lamp_decode(state_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ALL_RED;
         timer_q    <= '0;
         ns_pend_q  <= 1'b0;
         ew_pend_q  <= 1'b0;
         ped_pend_q <= 1'b0;
         last_ns_q  <= 1'b0;
         lamps_q    <= LAMPS_RESET;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         ns_pend_q  <= ns_pend_d;
         ew_pend_q  <= ew_pend_d;
         ped_pend_q <= ped_pend_d;
         last_ns_q  <= last_ns_d;
         lamps_q    <= lamps_d;
      end
   end

   assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk} = lamps_q;
   assign phase = state_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Self-checking bench for intersection_phase_scheduler: directed scenarios plus randomized run against a phase model.
module tb_intersection_phase_scheduler;
   localparam int GREEN_MIN = 8;
   localparam int GREEN_MAX = 32;
   localparam int YELLOW_T  = 4;
   localparam int ALLRED_T  = 2;
   localparam int WALK_T    = 10;
`ifdef PED_WALK_EN
   localparam bit PED_ON = 1'b1;
`else
   localparam bit PED_ON = 1'b0;
`endif
   // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, phase}
   localparam logic [9:0] RESET_OUT = 10'b1001000_000;

   logic       clk = 1'b0;
   logic       reset, enable, ns_req, ew_req, ped_req;
   logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
   logic [2:0] phase;
   logic [9:0] dut_out;

   int checks   = 0;
   int failures = 0;

   // Reference model state: phase code, cycles already spent in it, pending requests, last approach served.
   int m_phase, m_time;
   bit m_ns, m_ew, m_ped, m_last_ns;

   intersection_phase_scheduler #(
      .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .YELLOW_T(YELLOW_T),
      .ALLRED_T(ALLRED_T), .WALK_T(WALK_T), .CNT_W(6)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .ns_req(ns_req), .ew_req(ew_req), .ped_req(ped_req),
      .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
      .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
      .walk(walk), .phase(phase)
   );

   always #5 clk = ~clk;
   assign dut_out = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, phase};

   function automatic logic [9:0] exp_out(input int p);
      logic [6:0] l;
      case (p)
         1:       l = 7'b0011000;
         2:       l = 7'b0101000;
         4:       l = 7'b1000010;
         5:       l = 7'b1000100;
         7:       l = 7'b1001001;
         default: l = 7'b1001000;
      endcase
      return {l, 3'(p)};
   endfunction

   function automatic int pick_grant();
      if (m_ped) return 7;
      if (m_last_ns) begin
         if (m_ew) return 4;
         if (m_ns) return 1;
         return 4;
      end
      if (m_ns) return 1;
      if (m_ew) return 4;
      return 1;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_time = 0;
      m_ns = 0; m_ew = 0; m_ped = 0; m_last_ns = 0;
   endtask

   task automatic model_edge(input bit en, input bit nr, input bit er, input bit pr);
      int nxt;
      int done;
      nxt = m_phase;
      if (en) begin
         done = m_time + 1;
         case (m_phase)
            0: if (done == ALLRED_T) nxt = pick_grant();
            1: if (done == GREEN_MAX || (done >= GREEN_MIN && (m_ew || m_ped))) nxt = 2;
            2: if (done == YELLOW_T) nxt = 3;
            3: if (done == ALLRED_T) nxt = pick_grant();
            4: if (done == GREEN_MAX || (done >= GREEN_MIN && (m_ns || m_ped))) nxt = 5;
            5: if (done == YELLOW_T) nxt = 6;
            6: if (done == ALLRED_T) nxt = pick_grant();
            default: if (done == WALK_T) nxt = 0;
         endcase
      end
      if (nr && m_phase != 1) m_ns = 1;
      if (er && m_phase != 4) m_ew = 1;
      if (pr && PED_ON) m_ped = 1;
      if (nxt != m_phase) begin
         if (nxt == 1) begin m_ns = 0; m_last_ns = 1; end
         if (nxt == 4) begin m_ew = 0; m_last_ns = 0; end
         if (nxt == 7) m_ped = 0;
         m_time = 0;
      end else if (en) begin
         m_time = m_time + 1;
      end
      m_phase = nxt;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(enable, ns_req, ew_req, ped_req);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1; enable = 1; ns_req = 0; ew_req = 0; ped_req = 0;
      model_reset();
      @(posedge clk); #1;
      reset = 0;
   endtask

   task automatic async_reset_pulse(output logic [9:0] seen);
      #2; reset = 1; model_reset();
      #1; seen = dut_out;
      @(posedge clk); #1;
      reset = 0;
   endtask

   task automatic run_until_phase(input int p, input int budget, input string name);
      int n;
      n = 0;
      while (phase !== 3'(p) && n < budget) begin step(); n++; end
      checks++;
      if (phase !== 3'(p)) begin
         failures++;
         $display("FAIL %s_timeout: phase=%0d required=%0d", name, phase, p);
      end
   endtask

   task automatic test_reset();
      reset = 1; enable = 1; ns_req = 1; ew_req = 1; ped_req = 1;
      model_reset();
      @(posedge clk); #1;
      checks++;
      if (dut_out !== RESET_OUT) begin
         failures++; $display("FAIL reset_hold: got %b required %b", dut_out, RESET_OUT);
      end
      ns_req = 0; ew_req = 0; ped_req = 0;
      reset = 0;
      #2;
      checks++;
      if (dut_out !== RESET_OUT) begin
         failures++; $display("FAIL reset_release: got %b required %b", dut_out, RESET_OUT);
      end
      step();
      checks++;
      if (dut_out !== exp_out(0)) begin
         failures++; $display("FAIL reset_first_cycle: got %b required %b", dut_out, exp_out(0));
      end
   endtask

   task automatic test_default_cycle();
      int rp[$];
      int rl[$];
      int ep[5] = '{0, 1, 2, 3, 4};
      int el[5] = '{ALLRED_T, GREEN_MAX, YELLOW_T, ALLRED_T, 1};
      int both;
      apply_reset();
      both = 0;
      rp.push_back(int'(phase)); rl.push_back(1);
      for (int i = 0; i < ALLRED_T + GREEN_MAX + YELLOW_T + ALLRED_T; i++) begin
         step();
         if (ns_green && ew_green) both++;
         if (int'(phase) == rp[rp.size()-1]) rl[rl.size()-1]++;
         else begin rp.push_back(int'(phase)); rl.push_back(1); end
      end
      checks++;
      if (rp.size() != 5) begin
         failures++; $display("FAIL default_runs: got %0d phase runs required 5", rp.size());
      end
      for (int i = 0; i < rp.size() && i < 5; i++) begin
         checks++;
         if (rp[i] != ep[i] || rl[i] != el[i]) begin
            failures++;
            $display("FAIL default_seg%0d: got phase %0d x%0d required phase %0d x%0d", i, rp[i], rl[i], ep[i], el[i]);
         end
      end
      checks++;
      if (both != 0) begin
         failures++; $display("FAIL default_both_green: got %0d cycles required 0", both);
      end
   endtask

   task automatic test_early_exit();
      int g;
      int k;
      apply_reset();
      run_until_phase(1, 20, "early_ns_green");
      g = 1;
      while (g < 100) begin
         ew_req = (g == 3);
         step();
         ew_req = 0;
         if (phase !== 3'd1) break;
         g++;
      end
      checks++;
      if (g != GREEN_MIN || ns_yellow !== 1'b1) begin
         failures++; $display("FAIL early_green_len: got %0d cycles yellow=%b required %0d yellow=1", g, ns_yellow, GREEN_MIN);
      end
      k = 0;
      while (ew_green !== 1'b1 && k < 20) begin step(); k++; end
      checks++;
      if (k != YELLOW_T + ALLRED_T) begin
         failures++; $display("FAIL early_ew_latency: got %0d cycles required %0d", k, YELLOW_T + ALLRED_T);
      end
   endtask

   task automatic test_enable_freeze();
      int bad;
      int k;
      apply_reset();
      run_until_phase(2, 60, "freeze_reach_yellow");
      step();
      enable = 0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         ns_req = (i == 0);
         step();
         ns_req = 0;
         if (phase !== 3'd2 || ns_yellow !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++; $display("FAIL freeze_hold: got %0d disturbed cycles required 0", bad);
      end
      enable = 1;
      k = 0;
      while (phase === 3'd2 && k < 10) begin step(); k++; end
      checks++;
      if (k + 1 != YELLOW_T || phase !== 3'd3) begin
         failures++; $display("FAIL freeze_yellow_total: got %0d enabled cycles phase=%0d required %0d phase=3", k + 1, phase, YELLOW_T);
      end
      k = 0;
      while (phase === 3'd3 && k < 10) begin step(); k++; end
      checks++;
      if (phase !== 3'd1) begin
         failures++; $display("FAIL freeze_latched_req: got phase %0d required 1", phase);
      end
   endtask

   task automatic test_reset_mid_phase();
      logic [9:0] seen;
      int n;
      int g;
      apply_reset();
      run_until_phase(4, 80, "midreset_reach_ew");
      step();
      async_reset_pulse(seen);
      checks++;
      if (seen !== RESET_OUT) begin
         failures++; $display("FAIL midreset_ew_async: got %b required %b", seen, RESET_OUT);
      end
      run_until_phase(1, 20, "midreset_reach_ns");
      ew_req = 1; step(); ew_req = 0;
      async_reset_pulse(seen);
      checks++;
      if (seen !== RESET_OUT) begin
         failures++; $display("FAIL midreset_ns_async: got %b required %b", seen, RESET_OUT);
      end
      n = 0;
      while (phase !== 3'd1 && n < 20) begin step(); n++; end
      checks++;
      if (n != ALLRED_T) begin
         failures++; $display("FAIL midreset_first_green: got %0d cycles required %0d", n, ALLRED_T);
      end
      g = 1;
      while (g < 60) begin
         step();
         if (phase !== 3'd1) break;
         g++;
      end
      checks++;
      if (g != GREEN_MAX) begin
         failures++; $display("FAIL midreset_pend_cleared: got green %0d cycles required %0d", g, GREEN_MAX);
      end
   endtask

   task automatic test_back_to_back();
      int gp[$];
      int gl[$];
      int cur;
      int len;
      apply_reset();
      ns_req = 1; ew_req = 1;
      cur = -1; len = 0;
      for (int i = 0; i < 200 && gp.size() < 6; i++) begin
         step();
         if (phase === 3'd1 || phase === 3'd4) begin
            if (cur == int'(phase)) len++;
            else begin cur = int'(phase); len = 1; end
         end else if (cur != -1) begin
            gp.push_back(cur); gl.push_back(len); cur = -1;
         end
      end
      ns_req = 0; ew_req = 0;
      checks++;
      if (gp.size() != 6) begin
         failures++; $display("FAIL b2b_grant_count: got %0d grants required 6", gp.size());
      end
      for (int i = 0; i < gp.size(); i++) begin
         checks++;
         if (gp[i] != ((i % 2 == 0) ? 1 : 4) || gl[i] != GREEN_MIN) begin
            failures++;
            $display("FAIL b2b_grant%0d: got phase %0d x%0d required phase %0d x%0d", i, gp[i], gl[i], (i % 2 == 0) ? 1 : 4, GREEN_MIN);
         end
      end
   endtask

`ifdef PED_WALK_EN
   task automatic test_ped();
      int w;
      int a;
      apply_reset();
      run_until_phase(4, 80, "ped_reach_ew");
      ped_req = 1; step(); ped_req = 0;
      run_until_phase(6, 40, "ped_reach_clear");
      run_until_phase(7, 10, "ped_reach_walk");
      w = 0;
      while (phase === 3'd7 && w < 30) begin
         if (walk === 1'b1 && ns_red === 1'b1 && ew_red === 1'b1) w++;
         step();
      end
      checks++;
      if (w != WALK_T || phase !== 3'd0) begin
         failures++; $display("FAIL ped_walk_len: got %0d cycles next phase %0d required %0d then 0", w, phase, WALK_T);
      end
      a = 0;
      while (phase === 3'd0 && a < 10) begin step(); a++; end
      checks++;
      if (a != ALLRED_T || phase !== 3'd1) begin
         failures++; $display("FAIL ped_after_walk: got %0d all-red cycles then phase %0d required %0d then 1", a, phase, ALLRED_T);
      end
   endtask
`endif

   task automatic test_random();
      int errs;
      logic [9:0] want;
      apply_reset();
      errs = 0;
      for (int i = 0; i < 2500 && errs < 20; i++) begin
         enable  = ($urandom_range(0, 9) != 0);
         ns_req  = ($urandom_range(0, 24) == 0);
         ew_req  = ($urandom_range(0, 24) == 0);
         ped_req = ($urandom_range(0, 59) == 0);
         step();
         want = exp_out(m_phase);
         checks++;
         if (dut_out !== want) begin
            failures++; errs++;
            $display("FAIL random_cycle%0d: got %b required %b", i, dut_out, want);
         end
      end
      enable = 1; ns_req = 0; ew_req = 0; ped_req = 0;
   endtask

   initial begin
      reset = 1; enable = 0; ns_req = 0; ew_req = 0; ped_req = 0;
      model_reset();
      test_reset();
      test_default_cycle();
      test_early_exit();
      test_enable_freeze();
      test_reset_mid_phase();
      test_back_to_back();
`ifdef PED_WALK_EN
      test_ped();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

Sequences a two-approach intersection (north-south, east-west) so that exactly one approach holds right-of-way at a time. It latches vehicle and pedestrian requests and enforces minimum and maximum green times. Every handover passes through yellow and then all-red clearance. It sits above the per-approach light drivers and is the single source of their red/yellow/green outputs.

## Interface
- GREEN_MIN, 8: minimum green cycles per grant
- GREEN_MAX, 32: maximum green cycles per grant; must be greater than or equal to GREEN_MIN
- YELLOW_T, 4: yellow cycles
- ALLRED_T, 2: all-red clearance cycles
- WALK_T, 10: pedestrian walk cycles
- CNT_W, 6: phase timer width; must satisfy 2^CNT_W > every duration parameter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = run; 0 = freeze state and timer
- ns_req  in  1  north-south vehicle request pulse/level
- ew_req  in  1  east-west vehicle request pulse/level
- ped_req  in  1  pedestrian crossing request
- ns_red, ns_yellow, ns_green  out  1 each  north-south lamps, one-hot
- ew_red, ew_yellow, ew_green  out  1 each  east-west lamps, one-hot
- walk  out  1  pedestrian walk lamp
- phase  out  3  current state encoding

## Operation
- States and phase codes:
  - ALL_RED = 0
  - NS_GREEN = 1
  - NS_YELLOW = 2
  - NS_CLEAR = 3
  - EW_GREEN = 4
  - EW_YELLOW = 5
  - EW_CLEAR = 6
  - PED_WALK = 7
- Reset values: state ALL_RED, timer 0, all pending bits 0, last_served = EW. Outputs after reset: ns_red=1, ew_red=1, all other lamps 0, walk=0, phase=0.
- Pending bits:
  - ns_pend, ew_pend and ped_pend are set by their request input on any cycle in which enable is 1 or 0.
  - A pending bit is cleared on the edge that enters the corresponding green state or PED_WALK. On that edge, clear wins over a simultaneous set.
  - A request arriving while its own approach is green is ignored.
- Timer: reset to 0 on every state entry, then increments once per enabled cycle. A state exits on the edge where timer == duration-1.
- NS_GREEN / EW_GREEN:
  - Exit to yellow once timer ≥ GREEN_MIN-1 and (the opposing pending bit or ped_pend) is set.
  - Otherwise exit when timer == GREEN_MAX-1.
- Yellow lasts YELLOW_T cycles, then the matching CLEAR state. CLEAR lasts ALLRED_T cycles.
- Next-grant selection, made on exit from CLEAR or from ALL_RED:
  1. If ped_pend is set, go to PED_WALK.
  2. Otherwise, if the pending bit of the approach opposite last_served is set, grant that approach.
  3. Otherwise, if the pending bit of last_served is set, grant last_served.
  4. Otherwise, grant the approach opposite last_served.
- last_served updates on entry to a green state.
- PED_WALK: walk=1 with both reds lit for WALK_T cycles, then ALL_RED.
- Lamp outputs are a Moore decode of the state register.
- Invariant: ns_green and ew_green are never both 1. A non-red lamp is never lit during ALL_RED, CLEAR or PED_WALK.
- enable=0: the state, the timer and all outputs hold. Pending bits still latch.

## Timing
- Lamp and phase outputs change on the same clk edge as the state change; there is no added latency.
- A request pulse of one cycle is sufficient.
- Minimum latency from ew_req to ew_green while NS is green: (GREEN_MIN − elapsed green) + YELLOW_T + ALLRED_T cycles.
- Reset asserted mid-phase: all outputs go to their reset values asynchronously. After release, the first NS_GREEN begins ALLRED_T enabled cycles later.

## Configuration
- PED_WALK_EN defined: pedestrian support as described.
- PED_WALK_EN undefined:
  - ped_req is ignored and ped_pend is held at 0.
  - PED_WALK is never entered and walk is tied to 0.
  - Green exit considers only the opposing vehicle request.

## Test plan
- Reset release, enable=1, no requests:
  - ALL_RED for 2 cycles.
  - NS_GREEN for 32 cycles.
  - NS_YELLOW for 4 cycles.
  - NS_CLEAR for 2 cycles.
  - Then EW_GREEN; throughout, ns_green and ew_green are never both 1.
- ew_req pulsed at cycle 3 of NS_GREEN: ns_yellow asserts after exactly 8 NS_GREEN cycles, and ew_green asserts 6 cycles later.
- ped_req during EW_GREEN with PED_WALK_EN defined:
  - After EW_CLEAR, phase=7 and walk=1 for 10 cycles with ns_red=ew_red=1.
  - Then ALL_RED for 2 cycles, then NS_GREEN.
- enable deasserted for 5 cycles mid-NS_YELLOW: phase stays 2, and yellow still totals 4 enabled cycles.
- Reset asserted during EW_GREEN: ew_green drops immediately, ns_red=ew_red=1, and pending bits are cleared.
- Both ns_req and ew_req held high continuously: grants alternate NS/EW with each green lasting exactly 8 cycles.
